peripheral_bus_arbiter: RTL and testbench
=========================================

# peripheral_bus_arbiter

Two-master Wishbone arbiter in front of the peripheral bus decoder. It shares the single peripheral bus between the CPU data port (m0) and a secondary master such as DMA or debug (m1), using round-robin arbitration with bus locking for the whole `cyc` window. A watchdog aborts any transfer that a peripheral never acknowledges, returning an error to the requesting master. Its bus-side outputs drive the decoder's master inputs directly.

## Interface
- `TIMEOUT_CYCLES`, 255: cycles to wait for `ack_i` before aborting; 0 disables the watchdog.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i` in 1 each: master 0 Wishbone cycle, strobe and write-enable.
- `m0_addr_i`, `m0_data_i` in 32 each: master 0 address and write data.
- `m0_data_o` out 32: master 0 read data.
- `m0_ack_o`, `m0_err_o` out 1 each: master 0 acknowledge and error.
- `m1_*`: same set of ports as m0, for master 1.
- `cyc_o`, `stb_o`, `we_o` out 1 each: bus cycle, strobe and write-enable, to the decoder.
- `addr_o`, `data_o` out 32 each: bus address and write data.
- `data_i` in 32: bus read data.
- `ack_i` in 1: bus acknowledge.
- `grant_o` out 2: one-hot current owner (bit0 = m0, bit1 = m1); 00 when idle.

## Operation
- **States** (`arb_state_t`): `IDLE`, `BUSY_M0`, `BUSY_M1`, `ERR`.
- **Request:** `mX_req = mX_cyc_i & mX_stb_i`.
- **IDLE**
  - One request: go to that master's BUSY state.
  - Both request: grant the master not served last. `last_grant` is a 1-bit register; its reset value 1 means m0 wins the first tie.
  - Update `last_grant` on every grant.
- **BUSY_MX**
  - `cyc_o`, `stb_o`, `we_o`, `addr_o` and `data_o` pass through combinationally from master X.
  - `mX_data_o = data_i` and `mX_ack_o = ack_i`.
  - The other master sees ack = err = 0 and data = 0. Its request is held off; it is never dropped or acked.
- **Lock:** the grant is held while `mX_cyc_i` = 1, so multiple `stb` beats stay with one owner. When `mX_cyc_i` = 0, go to `IDLE` next cycle.
- **Watchdog**
  - Counter is cleared on grant, on `ack_i`, and on any cycle with `stb_o` = 0.
  - Otherwise it increments each BUSY cycle.
  - When the counter equals `TIMEOUT_CYCLES-1` and `ack_i` = 0, go to `ERR`.
- **ERR**
  - Lasts exactly one cycle.
  - `cyc_o` = `stb_o` = 0; `mX_err_o` = 1 and `mX_ack_o` = 0 for the owning master.
  - Next state: `BUSY_MX` if `mX_cyc_i` is still 1 (counter cleared), else `IDLE`.
- **Bus outputs when not BUSY:** all bus outputs are 0, including `addr_o` and `data_o`.
- **Width rules:** counter width is `$clog2(TIMEOUT_CYCLES+1)`, minimum 1. With `TIMEOUT_CYCLES` = 0, `ERR` is unreachable.

## Timing
- **Reset:** state `IDLE`, `last_grant` = 1, counter = 0. All outputs are 0 (`cyc_o`, `stb_o`, `we_o`, `addr_o`, `data_o`, `grant_o`, all `mX_ack_o`/`mX_err_o`/`mX_data_o`).
- **Grant latency:** request sampled in `IDLE` at edge N; `cyc_o`/`stb_o` and `grant_o` are high from cycle N+1.
- **Data path:** ack and read data are combinational; no added latency once granted.
- **Handoff:** at least one `IDLE` cycle between owners.
- **Ack vs timeout:** `ack_i` on the same cycle the counter hits the limit counts as ack; no `ERR`.
- **Early release:** `cyc` drop on the same cycle as `ack_i` completes the ack, then goes to `IDLE`.
- **Late ack:** `ack_i` arriving during `ERR` is ignored and not forwarded.
- **Reset mid-transfer:** immediate return to the reset values; the in-flight transfer is not acked.

## Structure
- **`peripheral_bus_pkg`**
  - `arb_state_t` enum.
  - `GRANT_M0` = 2'b01, `GRANT_M1` = 2'b10, `GRANT_NONE` = 2'b00.
  - `WB_ADDR_W` = 32, `WB_DATA_W` = 32.
- **Sub-module `peripheral_bus_watchdog`:** parameter `TIMEOUT_CYCLES`; inputs `clr`, `en`; output `expire`. It holds the counter and compare logic so it can be reused by other bus controllers.
- **Top level:** the FSM, `last_grant` and the pass-through muxes.

## Test plan
- **Single write:** m0 writes addr 0x1000_0004, data 0xDEAD_BEEF; slave acks 2 cycles after `stb_o`. Expect `cyc_o` at N+1, bus address/data matching, `m0_ack_o` 1 cycle, then `IDLE`, `grant_o` = 00.
- **Tie round-robin:** m0 and m1 both request from reset, 3 transfers each, 1-cycle ack. Expect grant order m0, m1, m0, m1, m0, m1, with one idle cycle between owners.
- **Lock:** m1 holds `cyc` for 4 `stb` beats while m0 requests. Expect no grant to m0 until m1 drops `cyc`; m0 sees ack = 0 and data = 0 throughout.
- **Timeout:** `TIMEOUT_CYCLES` = 8, m0 read, slave never acks. Expect `m0_err_o` high exactly one cycle, 8 cycles after `stb_o` rose; `cyc_o` = 0 in that cycle; ack on the limit cycle yields ack, not err.
- **Reset mid-transfer:** assert `rst_n` = 0 while in `BUSY_M1`. Expect all outputs 0 immediately; after release, a tie grants m0 first.

Source files
------------

// File: rtl/peripheral_bus_pkg.sv
// Shared types and constants for the peripheral bus arbiter and its watchdog.
package peripheral_bus_pkg;
  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  typedef enum logic [1:0] {IDLE, BUSY_M0, BUSY_M1, ERR} arb_state_t;

  typedef struct packed {
    logic                 cyc;
    logic                 stb;
    logic                 we;
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/peripheral_bus_watchdog.sv
// Cycle counter that flags a transfer left unacknowledged for TIMEOUT_CYCLES.
module peripheral_bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LIMIT = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt_q <= '0;
    else if (clr) cnt_q <= '0;
    else if (en)  cnt_q <= cnt_q + 1'b1;
  end

  // A clear on the limit cycle (ack) wins over expiry; 0 disables entirely.
  assign expire = (TIMEOUT_CYCLES > 0) && en && !clr && (cnt_q == LIMIT);
endmodule

// File: rtl/peripheral_bus_arbiter.sv
// Two-master round-robin Wishbone arbiter with cyc locking and an ack watchdog.
module peripheral_bus_arbiter
  import peripheral_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 m0_cyc_i,
  input  logic                 m0_stb_i,
  input  logic                 m0_we_i,
  input  logic [WB_ADDR_W-1:0] m0_addr_i,
  input  logic [WB_DATA_W-1:0] m0_data_i,
  output logic [WB_DATA_W-1:0] m0_data_o,
  output logic                 m0_ack_o,
  output logic                 m0_err_o,
  input  logic                 m1_cyc_i,
  input  logic                 m1_stb_i,
  input  logic                 m1_we_i,
  input  logic [WB_ADDR_W-1:0] m1_addr_i,
  input  logic [WB_DATA_W-1:0] m1_data_i,
  output logic [WB_DATA_W-1:0] m1_data_o,
  output logic                 m1_ack_o,
  output logic                 m1_err_o,
  output logic                 cyc_o,
  output logic                 stb_o,
  output logic                 we_o,
  output logic [WB_ADDR_W-1:0] addr_o,
  output logic [WB_DATA_W-1:0] data_o,
  input  logic [WB_DATA_W-1:0] data_i,
  input  logic                 ack_i,
  output logic [1:0]           grant_o
);
  arb_state_t state_q, state_d;
  logic       last_grant_q;  // 1 = m1 was served last; also names the owner in ERR
  logic       m0_req, m1_req, expire;
  wb_req_t    m0_rq, m1_rq, bus;

  assign m0_req = m0_cyc_i & m0_stb_i;
  assign m1_req = m1_cyc_i & m1_stb_i;
  assign m0_rq  = {m0_cyc_i, m0_stb_i, m0_we_i, m0_addr_i, m0_data_i};
  assign m1_rq  = {m1_cyc_i, m1_stb_i, m1_we_i, m1_addr_i, m1_data_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q <= state_d;
      if (state_d == BUSY_M0) last_grant_q <= 1'b0;
      if (state_d == BUSY_M1) last_grant_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (m0_req && (!m1_req || last_grant_q)) state_d = BUSY_M0;
        else if (m1_req)                         state_d = BUSY_M1;
      end
      BUSY_M0: begin
        if (!m0_cyc_i)   state_d = IDLE;
        else if (expire) state_d = ERR;
      end
      BUSY_M1: begin
        if (!m1_cyc_i)   state_d = IDLE;
        else if (expire) state_d = ERR;
      end
      ERR: begin
        if (last_grant_q) state_d = m1_cyc_i ? BUSY_M1 : IDLE;
        else              state_d = m0_cyc_i ? BUSY_M0 : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus       = '0;
    grant_o   = GRANT_NONE;
    m0_data_o = '0;
    m0_ack_o  = 1'b0;
    m0_err_o  = 1'b0;
    m1_data_o = '0;
    m1_ack_o  = 1'b0;
    m1_err_o  = 1'b0;
    case (state_q)
      BUSY_M0: begin
        bus       = m0_rq;
        grant_o   = GRANT_M0;
        m0_data_o = data_i;
        m0_ack_o  = ack_i;
      end
      BUSY_M1: begin
        bus       = m1_rq;
        grant_o   = GRANT_M1;
        m1_data_o = data_i;
        m1_ack_o  = ack_i;
      end
      ERR: begin
        // Bus is parked; a late ack_i here is deliberately dropped.
        grant_o  = last_grant_q ? GRANT_M1 : GRANT_M0;
        m0_err_o = !last_grant_q;
        m1_err_o = last_grant_q;
      end
      default: ;
    endcase
  end

  assign cyc_o  = bus.cyc;
  assign stb_o  = bus.stb;
  assign we_o   = bus.we;
  assign addr_o = bus.addr;
  assign data_o = bus.data;

  // stb_o is low in IDLE/ERR, so every grant starts from a cleared count.
  peripheral_bus_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (!stb_o || ack_i),
    .en     (state_q == BUSY_M0 || state_q == BUSY_M1),
    .expire (expire)
  );
endmodule

// File: tb/tb_peripheral_bus_arbiter.sv
// Directed bench for peripheral_bus_arbiter: write, round-robin, lock, timeout, reset.
module tb_peripheral_bus_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [31:0] m0_addr_i, m0_data_i, m0_data_o;
  logic        m0_ack_o, m0_err_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [31:0] m1_addr_i, m1_data_i, m1_data_o;
  logic        m1_ack_o, m1_err_o;
  logic        cyc_o, stb_o, we_o;
  logic [31:0] addr_o, data_o, data_i;
  logic        ack_i;
  logic [1:0]  grant_o;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  peripheral_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_data_o(m0_data_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_data_o(m1_data_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .addr_o(addr_o), .data_o(data_o),
    .data_i(data_i), .ack_i(ack_i), .grant_o(grant_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".cyc"},   32'(cyc_o),     32'h0);
    chk({tag, ".stb"},   32'(stb_o),     32'h0);
    chk({tag, ".we"},    32'(we_o),      32'h0);
    chk({tag, ".addr"},  addr_o,         32'h0);
    chk({tag, ".data"},  data_o,         32'h0);
    chk({tag, ".grant"}, 32'(grant_o),   32'h0);
    chk({tag, ".m0ack"}, 32'(m0_ack_o),  32'h0);
    chk({tag, ".m0err"}, 32'(m0_err_o),  32'h0);
    chk({tag, ".m0dat"}, m0_data_o,      32'h0);
    chk({tag, ".m1ack"}, 32'(m1_ack_o),  32'h0);
    chk({tag, ".m1err"}, 32'(m1_err_o),  32'h0);
    chk({tag, ".m1dat"}, m1_data_o,      32'h0);
  endtask

  // Inputs change 1 time unit after a rising edge; checks happen on the falling edge.
  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_m0(input logic c, input logic w, input logic [31:0] a, input logic [31:0] d);
    m0_cyc_i = c; m0_stb_i = c; m0_we_i = w; m0_addr_i = a; m0_data_i = d;
  endtask

  task automatic set_m1(input logic c, input logic w, input logic [31:0] a, input logic [31:0] d);
    m1_cyc_i = c; m1_stb_i = c; m1_we_i = w; m1_addr_i = a; m1_data_i = d;
  endtask

  initial begin
    logic [1:0] exp_g;
    rst_n = 1'b0; ack_i = 1'b0; data_i = '0;
    set_m0(0, 0, 0, 0); set_m1(0, 0, 0, 0);
    mid(); chk_all_zero("reset");
    nxt(); rst_n = 1'b1;

    // Single write, slave acks two cycles after stb_o
    set_m0(1, 1, 32'h1000_0004, 32'hDEAD_BEEF);
    mid(); chk("wr.idle_cyc", 32'(cyc_o), 0);
    nxt(); mid();
    chk("wr.cyc", 32'(cyc_o), 1); chk("wr.stb", 32'(stb_o), 1); chk("wr.we", 32'(we_o), 1);
    chk("wr.addr", addr_o, 32'h1000_0004); chk("wr.data", data_o, 32'hDEAD_BEEF);
    chk("wr.grant", 32'(grant_o), 32'(2'b01)); chk("wr.noack", 32'(m0_ack_o), 0);
    nxt(); mid(); chk("wr.noack2", 32'(m0_ack_o), 0);
    nxt(); ack_i = 1'b1; mid(); chk("wr.ack", 32'(m0_ack_o), 1);
    nxt(); ack_i = 1'b0; set_m0(0, 0, 0, 0); mid(); chk("wr.ack_once", 32'(m0_ack_o), 0);
    nxt(); mid(); chk_all_zero("wr.idle");

    // Tie round-robin from reset
    nxt(); rst_n = 1'b0; nxt(); rst_n = 1'b1;
    set_m0(1, 0, 32'h0000_0100, 0); set_m1(1, 0, 32'h0000_0200, 0);
    mid(); chk("rr.idle0", 32'(grant_o), 0);
    for (int i = 0; i < 6; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      nxt(); ack_i = 1'b1; mid();
      chk($sformatf("rr.grant%0d", i), 32'(grant_o), 32'(exp_g));
      chk($sformatf("rr.ack%0d", i), 32'({m1_ack_o, m0_ack_o}), 32'(exp_g));
      nxt(); ack_i = 1'b0;
      if (exp_g == 2'b01) set_m0(0, 0, 0, 0); else set_m1(0, 0, 0, 0);
      nxt();
      if (i == 5) begin
        set_m0(0, 0, 0, 0); set_m1(0, 0, 0, 0);
      end else if (exp_g == 2'b01) set_m0(1, 0, 32'h0000_0100, 0);
      else set_m1(1, 0, 32'h0000_0200, 0);
      mid(); chk($sformatf("rr.gap%0d", i), 32'(grant_o), 0);
    end

    // Lock: m1 keeps cyc for 4 beats while m0 waits
    set_m1(1, 0, 32'h2000_0000, 0);
    nxt(); set_m0(1, 1, 32'h2000_0040, 32'h5555_AAAA);
    for (int k = 0; k < 4; k++) begin
      ack_i = 1'b1; data_i = 32'hA5A5_0000 + 32'(k);
      mid();
      chk($sformatf("lk.grant%0d", k), 32'(grant_o), 32'(2'b10));
      chk($sformatf("lk.m1ack%0d", k), 32'(m1_ack_o), 1);
      chk($sformatf("lk.m1dat%0d", k), m1_data_o, 32'hA5A5_0000 + 32'(k));
      chk($sformatf("lk.m0ack%0d", k), 32'(m0_ack_o), 0);
      chk($sformatf("lk.m0dat%0d", k), m0_data_o, 0);
      nxt();
    end
    ack_i = 1'b0; set_m1(0, 0, 0, 0);
    mid(); chk("lk.rel_m0ack", 32'(m0_ack_o), 0); chk("lk.rel_grant", 32'(grant_o), 32'(2'b10));
    nxt(); mid(); chk("lk.gap", 32'(grant_o), 0);
    nxt(); ack_i = 1'b1; mid();
    chk("lk.m0grant", 32'(grant_o), 32'(2'b01)); chk("lk.m0addr", addr_o, 32'h2000_0040);
    chk("lk.m0data", data_o, 32'h5555_AAAA); chk("lk.m0ack", 32'(m0_ack_o), 1);
    nxt(); ack_i = 1'b0; set_m0(0, 0, 0, 0);
    nxt(); data_i = '0;

    // Timeout with TIMEOUT_CYCLES = 8, then ack exactly on the limit cycle
    set_m0(1, 0, 32'h3000_0000, 0);
    nxt(); mid(); chk("to.cyc", 32'(cyc_o), 1); chk("to.err0", 32'(m0_err_o), 0);
    for (int k = 1; k < 8; k++) begin
      nxt(); mid(); chk($sformatf("to.wait%0d", k), 32'(m0_err_o), 0);
    end
    nxt(); ack_i = 1'b1; mid();
    chk("to.err", 32'(m0_err_o), 1); chk("to.err_cyc", 32'(cyc_o), 0);
    chk("to.err_stb", 32'(stb_o), 0); chk("to.late_ack", 32'(m0_ack_o), 0);
    chk("to.m1err", 32'(m1_err_o), 0);
    nxt(); ack_i = 1'b0; mid();
    chk("to.err_once", 32'(m0_err_o), 0); chk("to.regrant", 32'(cyc_o), 1);
    for (int k = 1; k < 7; k++) begin
      nxt(); mid(); chk($sformatf("to.wait2_%0d", k), 32'(m0_err_o), 0);
    end
    nxt(); ack_i = 1'b1; data_i = 32'h1234_5678; mid();
    chk("to.lim_ack", 32'(m0_ack_o), 1); chk("to.lim_err", 32'(m0_err_o), 0);
    chk("to.lim_dat", m0_data_o, 32'h1234_5678);
    nxt(); ack_i = 1'b0; data_i = '0; set_m0(0, 0, 0, 0); mid();
    chk("to.post_err", 32'(m0_err_o), 0);
    nxt(); mid(); chk_all_zero("to.idle");

    // Reset mid-transfer while m1 owns the bus
    set_m1(1, 1, 32'h4000_0000, 32'h0BAD_F00D);
    nxt(); mid(); chk("rs.grant", 32'(grant_o), 32'(2'b10));
    nxt(); ack_i = 1'b1; rst_n = 1'b0; #1;
    chk_all_zero("rs.async");
    set_m0(1, 0, 32'h4000_0010, 0);
    nxt(); ack_i = 1'b0; rst_n = 1'b1;
    mid(); chk("rs.idle", 32'(grant_o), 0);
    nxt(); mid(); chk("rs.tie_m0", 32'(grant_o), 32'(2'b01));
    set_m0(0, 0, 0, 0); set_m1(0, 0, 0, 0);
    nxt(); nxt();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
